// File: rtl/frame_write_arbiter.sv
// rtl/frame_write_arbiter.sv - N-channel burst write arbiter with a registered frame buffer write port
// Optional build macro: FRAME_WRITE_ARBITER_FIXED_PRIORITY_EN (fixed lowest-index priority instead of round-robin)
module frame_write_arbiter #(
  parameter int CHANNELS   = 3,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 1,
  parameter int MAX_BURST  = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS-1:0]            req,
  input  logic [CHANNELS-1:0]            last,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] addr,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data,
  output logic [CHANNELS-1:0]            grant,
  output logic                           write_enable,
  output logic [ADDR_WIDTH-1:0]          write_addr,
  output logic [DATA_WIDTH-1:0]          write_data,
  output logic                           busy
);

  localparam int PTR_W = $clog2(CHANNELS);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(CHANNELS - 1);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t                r_state, w_state_nxt;
  logic [CHANNELS-1:0]   r_grant, w_grant_nxt;
  logic [PTR_W-1:0]      r_owner, w_owner_nxt;
  logic [PTR_W-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0]      r_beat_cnt, w_beat_cnt_nxt;
  logic                  r_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_waddr, w_waddr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;

  logic                  w_found;
  logic [PTR_W-1:0]      w_winner;
  int                    w_idx;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_beat;
  logic                  w_last_beat;

  // Pick the next owner among requesters: rotating start point, or always channel 0 first
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef FRAME_WRITE_ARBITER_FIXED_PRIORITY_EN
      w_idx = i;
`else
      w_idx = (int'(r_rr_ptr) + i) % CHANNELS;
`endif
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = PTR_W'(w_idx);
      end
    end
  end

  // Route the owning channel's address/data; other channels never reach the port
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (r_grant[k]) begin
        w_sel_addr = addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data = data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // grant is zero outside OWN, so these only fire for the current owner
  assign w_beat      = |(req & r_grant);
  assign w_last_beat = |(req & last & r_grant);

  // Next-state and registered-output logic for the IDLE/OWN controller
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_owner_nxt    = r_owner;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    w_we_nxt       = 1'b0;
    w_waddr_nxt    = r_waddr;
    w_wdata_nxt    = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt    = S_OWN;
          w_grant_nxt    = CHANNELS'(1) << w_winner;
          w_owner_nxt    = w_winner;
          w_beat_cnt_nxt = '0;
        end
      end
      S_OWN: begin
        if (w_beat) begin
          w_we_nxt       = 1'b1;
          w_waddr_nxt    = w_sel_addr;
          w_wdata_nxt    = w_sel_data;
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end
        // Release on final beat, forced limit, or owner dropping its request
        if (!w_beat || w_last_beat || (r_beat_cnt == CNT_LAST)) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
`ifndef FRAME_WRITE_ARBITER_FIXED_PRIORITY_EN
          w_rr_ptr_nxt = (r_owner == PTR_MAX) ? '0 : r_owner + PTR_W'(1);
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight burst immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_we       <= w_we_nxt;
      r_waddr    <= w_waddr_nxt;
      r_wdata    <= w_wdata_nxt;
    end
  end

  assign grant        = r_grant;
  assign write_enable = r_we;
  assign write_addr   = r_waddr;
  assign write_data   = r_wdata;
  assign busy         = (r_state == S_OWN);

endmodule

// File: tb/tb_frame_write_arbiter.sv
// tb/tb_frame_write_arbiter.sv - scoreboard bench for frame_write_arbiter
module tb_frame_write_arbiter;

  localparam int CH = 3;
  localparam int AW = 19;
  localparam int DW = 1;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic [CH-1:0]    req   = '0;
  logic [CH-1:0]    last  = '0;
  logic [CH*AW-1:0] addr  = '0;
  logic [CH*DW-1:0] data  = '0;
  logic [CH-1:0]    grant;
  logic             write_enable;
  logic [AW-1:0]    write_addr;
  logic [DW-1:0]    write_data;
  logic             busy;

  frame_write_arbiter #(
    .CHANNELS(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .addr(addr), .data(data),
    .grant(grant), .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .busy(busy)
  );

  typedef struct {
    int          ch;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic        l;
  } beat_t;

  beat_t            sq[$];
  logic [AW+DW-1:0] exp_wr[$];
  int               exp_gr[$];
  int               gr_cyc[$];
  int               n_chk = 0;
  int               n_fail = 0;
  int               cyc = 0;
  logic [CH-1:0]    prev_grant = '0;
  logic [CH-1:0]    drv_taken;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find_first(input int k);
    foreach (sq[i]) if (sq[i].ch == k) return i;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [CH-1:0] g);
    for (int k = 0; k < CH; k++) if (g[k]) return k;
    return -1;
  endfunction

  // Queue a burst; only the first nexp beats are expected to reach the write port
  task automatic add_burst(input int ch, input int base, input int n, input bit with_last, input int nexp);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.ch = ch;
      b.a  = AW'(base + i);
      b.d  = DW'(i % 2);
      b.l  = with_last && (i == n - 1);
      sq.push_back(b);
      if (i < nexp) exp_wr.push_back({b.d, b.a});
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((sq.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      n++;
    end
    check(tag, 32'(n < 300), 32'd1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  // Drawer model: consume a beat when it was accepted, then present the next one
  always @(posedge clk) begin
    cyc++;
    drv_taken = req & grant;
    #1;
    for (int k = 0; k < CH; k++) begin
      int idx;
      if (drv_taken[k]) begin
        idx = find_first(k);
        if (idx >= 0) sq.delete(idx);
      end
      idx = find_first(k);
      if (idx >= 0) begin
        req[k]             = 1'b1;
        last[k]            = sq[idx].l;
        addr[k*AW +: AW]   = sq[idx].a;
        data[k*DW +: DW]   = sq[idx].d;
      end else begin
        req[k]  = 1'b0;
        last[k] = 1'b0;
      end
    end
  end

  // Write port and grant monitor against the expectation queues
  always @(negedge clk) begin
    if (rst_n) begin
      check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
      if (write_enable) begin
        if (exp_wr.size() == 0) check("wr_spurious", 32'(exp_wr.size()), 32'd1);
        else check("wr_beat", 32'({write_data, write_addr}), 32'(exp_wr.pop_front()));
      end
      if (grant != '0 && prev_grant == '0) begin
        gr_cyc.push_back(cyc);
        if (exp_gr.size() == 0) check("grant_spurious", 32'(exp_gr.size()), 32'd1);
        else check("grant_order", 32'(onehot_idx(grant)), 32'(exp_gr.pop_front()));
      end
    end
    prev_grant = grant;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b;
    repeat (2) @(posedge clk);
    #2;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(write_addr), 32'd0);
    rst_n = 1'b1;

    // Single ch0 burst, 4 beats at 10..13
    add_burst(0, 10, 4, 1'b1, 4);
    exp_gr.push_back(0);
    @(posedge clk);
    @(posedge clk); #2;
    check("b_grant", 32'(grant), 32'b001);
    check("b_busy", 32'(busy), 32'd1);
    check("b_we_early", 32'(write_enable), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      check("b_we", 32'(write_enable), 32'd1);
      check("b_grant_hold", 32'(grant), (i == 3) ? 32'b000 : 32'b001);
    end
    @(posedge clk); #2;
    check("b_we_end", 32'(write_enable), 32'd0);
    check("b_busy_end", 32'(busy), 32'd0);

`ifdef FRAME_WRITE_ARBITER_FIXED_PRIORITY_EN
    // Fixed priority: ch0 keeps winning while it requests, ch2 waits
    do_reset();
    for (int i = 0; i < 4; i++) add_burst(0, 70 + i, 1, 1'b1, 1);
    add_burst(2, 80, 1, 1'b1, 1);
    exp_gr.push_back(0); exp_gr.push_back(0); exp_gr.push_back(0); exp_gr.push_back(0);
    exp_gr.push_back(2);
    wait_done("f_done");
`else
    // Round-robin contention from reset
    do_reset();
    b = gr_cyc.size();
    add_burst(0, 100, 2, 1'b1, 2);
    add_burst(1, 110, 2, 1'b1, 2);
    add_burst(2, 120, 2, 1'b1, 2);
    add_burst(0, 102, 2, 1'b1, 2);
    exp_gr.push_back(0); exp_gr.push_back(1); exp_gr.push_back(2); exp_gr.push_back(0);
    wait_done("c_done");
    check("c_grants", 32'(gr_cyc.size() - b), 32'd4);
    if (gr_cyc.size() >= b + 4)
      for (int i = 1; i < 4; i++) check("c_gap", 32'(gr_cyc[b+i] - gr_cyc[b+i-1]), 32'd3);
`endif

    // Forced release after MB beats, others served before ch2 again
    do_reset();
    b = gr_cyc.size();
    add_burst(2, 200, 6, 1'b0, 6);
    @(posedge clk);
    @(posedge clk); #2;
    check("d_grant2", 32'(grant), 32'b100);
    add_burst(0, 30, 1, 1'b1, 1);
    add_burst(1, 40, 1, 1'b1, 1);
    // move ch0/ch1 writes ahead of ch2's remaining beats 204/205
    begin
      logic [AW+DW-1:0] t0, t1;
      t0 = exp_wr.pop_back(); t1 = exp_wr.pop_back();
      exp_wr.pop_back(); exp_wr.pop_back();
      exp_wr.push_back(t1); exp_wr.push_back(t0);
      exp_wr.push_back({1'b0, AW'(204)}); exp_wr.push_back({1'b1, AW'(205)});
    end
    exp_gr.push_back(2); exp_gr.push_back(0); exp_gr.push_back(1); exp_gr.push_back(2);
    wait_done("d_done");
    if (gr_cyc.size() >= b + 2) check("d_forced_gap", 32'(gr_cyc[b+1] - gr_cyc[b]), 32'(MB + 1));
    else check("d_grant_count", 32'(gr_cyc.size() - b), 32'd2);

    // Abort: ch1 drops req after 2 beats
    do_reset();
    add_burst(1, 50, 2, 1'b0, 2);
    exp_gr.push_back(1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #2;
    check("e_we1", 32'(write_enable), 32'd1);
    @(posedge clk); #2;
    check("e_hold", 32'(grant), 32'b010);
    check("e_we2", 32'(write_enable), 32'd1);
    @(posedge clk); #2;
    check("e_release", 32'(grant), 32'd0);
    check("e_no_spurious", 32'(write_enable), 32'd0);
    check("e_addr_hold", 32'(write_addr), 32'd51);
    @(posedge clk); #2;
    check("e_busy", 32'(busy), 32'd0);

    // Reset in the middle of a ch1 burst
    add_burst(1, 60, 4, 1'b1, 1);
    exp_gr.push_back(1);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    sq.delete();
    #1;
    check("r_grant", 32'(grant), 32'd0);
    check("r_we", 32'(write_enable), 32'd0);
    check("r_busy", 32'(busy), 32'd0);
    check("r_addr", 32'(write_addr), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("r_idle_grant", 32'(grant), 32'd0);
    check("r_idle_busy", 32'(busy), 32'd0);

    check("wr_leftover", 32'(exp_wr.size()), 32'd0);
    check("grant_leftover", 32'(exp_gr.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
